// File: rtl/aux_run_pkg.sv
// Shared encodings for the run/step/breakpoint controller.
// State and stop-cause values are visible on the status outputs and read by the display mux.
package aux_run_pkg;

  localparam int unsigned StW = 2;
  localparam int unsigned CsW = 2;

  typedef enum logic [StW-1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } run_state_e;

  typedef enum logic [CsW-1:0] {
    CS_NONE    = 2'd0,
    CS_SYSCALL = 2'd1,
    CS_BREAK   = 2'd2,
    CS_BUDGET  = 2'd3
  } stop_cause_e;

  // Packed status word as seen by the display mux
  typedef struct packed {
    logic [StW-1:0] state;
    logic [CsW-1:0] cause;
  } run_status_t;

endpackage

// File: rtl/aux_run_ctrl_if.sv
// Core-side bundle of the run controller: enable out, halt/PC in, status out.
// The controller takes the master modport; the core and the display take the slave modport.
interface aux_run_ctrl_if #(
  parameter int unsigned PcBit = 32
);

  logic                        en;
  logic                        core_halt;
  logic [PcBit-1:0]            core_pc;
  logic [aux_run_pkg::StW-1:0] state;
  logic [aux_run_pkg::CsW-1:0] cause;

  modport master (
    output en,
    output state,
    output cause,
    input  core_halt,
    input  core_pc
  );

  modport slave (
    input  en,
    input  state,
    input  cause,
    output core_halt,
    output core_pc
  );

endinterface

// File: rtl/aux_debounce.sv
// Button conditioner: 2-FF synchronizer, level filter, single-cycle press pulse.
// The pulse lands DebounceCnt+2 edges after the first edge that samples the pressed level.
module aux_debounce #(
  parameter int unsigned DebounceCnt = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CntW = (DebounceCnt < 2) ? 1 : $clog2(DebounceCnt);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q, level_d;
  logic            prev_q;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has differed for DebounceCnt cycles in a row
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = level_q & ~prev_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DebounceCnt - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/aux_run_ctrl.sv
// Run/step/breakpoint controller gating the core enable in the core clock domain.
// Handles debounced resume/step buttons, a one-shot-rearming PC breakpoint and an instruction budget.
module aux_run_ctrl
  import aux_run_pkg::*;
#(
  parameter int unsigned DebounceCnt = 4,
  parameter int unsigned PcBit       = 32,
  parameter int unsigned BudgetBit   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_resume,
  input  logic                 btn_step,
  input  logic                 run_mode,
  input  logic                 bp_en,
  input  logic [PcBit-1:0]     bp_addr,
  input  logic [BudgetBit-1:0] budget,
  aux_run_ctrl_if.master       core
);

  run_state_e           state_q, state_d;
  stop_cause_e          cause_q, cause_d;
  logic [BudgetBit-1:0] cnt_q, cnt_d;
  logic                 bp_armed_q, bp_armed_d;
  logic                 resume_pulse;
  logic                 step_pulse;
  logic                 bp_hit_c;
  logic                 en_c;
  run_status_t          status;

  aux_debounce #(.DebounceCnt(DebounceCnt)) u_resume (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_resume),
    .pulse   (resume_pulse)
  );

  aux_debounce #(.DebounceCnt(DebounceCnt)) u_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_step),
    .pulse   (step_pulse)
  );

  // Disarmed on resume so the instruction sitting at bp_addr can execute once
  assign bp_hit_c = bp_en & bp_armed_q & (core.core_pc == bp_addr);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    bp_armed_d = bp_armed_q;
    en_c       = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (resume_pulse & run_mode) begin
          state_d    = ST_RUN;
          cnt_d      = budget;
          bp_armed_d = 1'b0;
          cause_d    = CS_NONE;
        end else if (step_pulse | resume_pulse) begin
          state_d    = ST_STEP;
          bp_armed_d = 1'b0;
          cause_d    = CS_NONE;
        end
      end
      ST_STEP: begin
        en_c       = 1'b1;
        state_d    = ST_HALT;
        bp_armed_d = 1'b1;
        cause_d    = core.core_halt ? CS_SYSCALL : CS_NONE;
      end
      ST_RUN: begin
        if (bp_hit_c) begin
          state_d = ST_HALT;
          cause_d = CS_BREAK;
        end else begin
          en_c       = 1'b1;
          bp_armed_d = 1'b1;
          // A zero count means unlimited, so it is never decremented
          if (cnt_q != '0) begin
            cnt_d = cnt_q - BudgetBit'(1);
          end
          if (core.core_halt) begin
            state_d = ST_HALT;
            cause_d = CS_SYSCALL;
          end else if (cnt_q == BudgetBit'(1)) begin
            state_d = ST_HALT;
            cause_d = CS_BUDGET;
          end else if (!run_mode) begin
            state_d = ST_HALT;
            cause_d = CS_NONE;
          end
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HALT;
      cause_q    <= CS_NONE;
      cnt_q      <= '0;
      bp_armed_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      bp_armed_q <= bp_armed_d;
    end
  end

  assign status.state = state_q;
  assign status.cause = cause_q;

  assign core.en    = en_c;
  assign core.state = status.state;
  assign core.cause = status.cause;

endmodule

// File: tb/tb_aux_run_ctrl.sv
// Self-checking bench for aux_run_ctrl: a small wrapping-PC core model drives the DUT and
// each run is compared against an instruction-level reference of the stop rules.
module tb_aux_run_ctrl;
  import aux_run_pkg::*;

  localparam int unsigned DebounceCnt = 4;
  localparam int unsigned PcBit       = 32;
  localparam int unsigned BudgetBit   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 btn_resume;
  logic                 btn_step;
  logic                 run_mode;
  logic                 bp_en;
  logic [PcBit-1:0]     bp_addr;
  logic [BudgetBit-1:0] budget;

  aux_run_ctrl_if #(.PcBit(PcBit)) cif ();

  aux_run_ctrl #(
    .DebounceCnt (DebounceCnt),
    .PcBit       (PcBit),
    .BudgetBit   (BudgetBit)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_resume (btn_resume),
    .btn_step   (btn_step),
    .run_mode   (run_mode),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .budget     (budget),
    .core       (cif)
  );

  always #5 clk = ~clk;

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic        halt_en;
  logic [31:0] halt_pc;
  logic [31:0] exec_q[$];
  logic [31:0] exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One core cycle: log the instruction if enabled, advance the PC (wraps at 0x40) after the edge
  task automatic tick();
    logic e;
    e = cif.en;
    if (e) exec_q.push_back(cif.core_pc);
    @(posedge clk);
    #1;
    if (e) cif.core_pc = (cif.core_pc + 32'd4) & 32'h3F;
    cif.core_halt = halt_en && (cif.core_pc == halt_pc);
    #1;
  endtask

  // Instruction-level reference for one resume in free-run mode
  function automatic logic [1:0] model_run(input logic [31:0] start, input int unsigned bud,
                                           input bit bpe, input logic [31:0] bpa,
                                           input bit he, input logic [31:0] hpc);
    logic [31:0] pc = start;
    bit          armed = 1'b0;
    int unsigned n = 0;
    exp_q.delete();
    for (int i = 0; i < 1000; i++) begin
      if (bpe && armed && pc == bpa) return 2'(CS_BREAK);
      exp_q.push_back(pc);
      n++;
      armed = 1'b1;
      if (he && pc == hpc) return 2'(CS_SYSCALL);
      if (bud != 0 && n == bud) return 2'(CS_BUDGET);
      pc = (pc + 32'd4) & 32'h3F;
    end
    return 2'(CS_NONE);
  endfunction

  task automatic do_run(input string name, input int unsigned bud, input bit bpe,
                        input logic [31:0] bpa, input bit he, input logic [31:0] hpc,
                        input bit extra);
    logic [1:0] ec;
    bit         ran = 1'b0;
    bit         done = 1'b0;
    int         n;
    bp_en = bpe; bp_addr = bpa; halt_en = he; halt_pc = hpc;
    budget = 16'(bud); run_mode = 1'b1;
    cif.core_halt = he && (cif.core_pc == hpc);
    #1;
    ec = model_run(cif.core_pc, bud, bpe, bpa, he, hpc);
    exec_q.delete();
    for (int t = 0; t < 400 && !done; t++) begin
      btn_resume = (t < 8) || (extra && t >= 16 && t < 24);
      tick();
      if (cif.state == ST_RUN) ran = 1'b1;
      if (ran && t >= 40 && cif.state == ST_HALT) done = 1'b1;
    end
    btn_resume = 1'b0;
    cmp_cnt++;
    if (!done) begin
      err_cnt++;
      $display("FAIL %s timeout: ran=%0d state=%0d, required a completed run", name, ran, cif.state);
    end
    cmp_cnt++;
    if (exec_q.size() != exp_q.size()) begin
      err_cnt++;
      $display("FAIL %s count: executed %0d, required %0d", name, exec_q.size(), exp_q.size());
    end
    n = (exec_q.size() < exp_q.size()) ? exec_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      cmp_cnt++;
      if (exec_q[i] !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL %s pc[%0d]: got %0h, required %0h", name, i, exec_q[i], exp_q[i]);
      end
    end
    cmp_cnt++;
    if (cif.cause !== ec) begin
      err_cnt++;
      $display("FAIL %s cause: got %0d, required %0d", name, cif.cause, ec);
    end
    halt_en = 1'b0; bp_en = 1'b0; cif.core_halt = 1'b0;
    #1;
  endtask

  task automatic do_step(input string name, input bit use_resume, input int width,
                         input bit he, input bit bph, input logic [1:0] exp_c);
    logic [31:0] start;
    logic [31:0] first;
    int          nstep = 0;
    run_mode = 1'b0;
    start = cif.core_pc;
    halt_en = he; halt_pc = start; bp_en = bph; bp_addr = start;
    cif.core_halt = he;
    #1;
    exec_q.delete();
    for (int t = 0; t < 30; t++) begin
      if (use_resume) btn_resume = (t < width);
      else            btn_step   = (t < width);
      tick();
      if (cif.state == ST_STEP) nstep++;
    end
    btn_resume = 1'b0; btn_step = 1'b0; halt_en = 1'b0; bp_en = 1'b0; cif.core_halt = 1'b0;
    #1;
    first = (exec_q.size() > 0) ? exec_q[0] : 32'hFFFF_FFFF;
    cmp_cnt++;
    if (nstep != 1) begin
      err_cnt++; $display("FAIL %s step_cycles: got %0d, required 1", name, nstep);
    end
    cmp_cnt++;
    if (exec_q.size() != 1) begin
      err_cnt++; $display("FAIL %s en_cycles: got %0d, required 1", name, exec_q.size());
    end
    cmp_cnt++;
    if (first !== start) begin
      err_cnt++; $display("FAIL %s step_pc: got %0h, required %0h", name, first, start);
    end
    cmp_cnt++;
    if (cif.state !== 2'(ST_HALT)) begin
      err_cnt++; $display("FAIL %s state: got %0d, required 0", name, cif.state);
    end
    cmp_cnt++;
    if (cif.cause !== exp_c) begin
      err_cnt++; $display("FAIL %s cause: got %0d, required %0d", name, cif.cause, exp_c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_resume = 1'b1; btn_step = 1'b0; run_mode = 1'b1; budget = '0;
    bp_en = 1'b0; bp_addr = '0; halt_en = 1'b0; halt_pc = '0;
    cif.core_pc = '0; cif.core_halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++;
    if (cif.state !== 2'(ST_HALT)) begin err_cnt++; $display("FAIL reset_state: got %0d, required 0", cif.state); end
    cmp_cnt++;
    if (cif.cause !== 2'(CS_NONE)) begin err_cnt++; $display("FAIL reset_cause: got %0d, required 0", cif.cause); end
    cmp_cnt++;
    if (cif.en !== 1'b0) begin err_cnt++; $display("FAIL reset_en: got %0b, required 0", cif.en); end
    rst_n = 1'b1;
    #1;
    repeat (7) tick();
    cmp_cnt++;
    if (cif.state !== 2'(ST_HALT) || cif.en !== 1'b0) begin
      err_cnt++; $display("FAIL early_resume: state=%0d en=%0b, required state 0 en 0", cif.state, cif.en);
    end
    tick();
    cmp_cnt++;
    if (cif.state !== 2'(ST_RUN) || cif.en !== 1'b1) begin
      err_cnt++; $display("FAIL resume_latency: state=%0d en=%0b, required state 1 en 1", cif.state, cif.en);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      cmp_cnt++;
      if (cif.en !== 1'b1) begin
        err_cnt++; $display("FAIL free_run_en cycle %0d: got %0b, required 1", k, cif.en);
      end
    end
    run_mode = 1'b0;
    tick();
    cmp_cnt++;
    if (cif.state !== 2'(ST_HALT) || cif.cause !== 2'(CS_NONE)) begin
      err_cnt++; $display("FAIL mode_stop: state=%0d cause=%0d, required 0/0", cif.state, cif.cause);
    end
    repeat (20) tick();
    cmp_cnt++;
    if (cif.state !== 2'(ST_HALT)) begin
      err_cnt++; $display("FAIL held_single_pulse: state=%0d, required 0", cif.state);
    end
    btn_resume = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_budget();
    do_run("budget5_a", 5, 1'b0, '0, 1'b0, '0, 1'b0);
    do_run("budget5_b", 5, 1'b0, '0, 1'b0, '0, 1'b0);
    do_run("budget1", 1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_run("budget_rand", $urandom_range(2, 12), 1'b0, '0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_breakpoint();
    cif.core_pc = '0;
    #1;
    do_run("bp_first", 0, 1'b1, 32'h10, 1'b0, '0, 1'b0);
    do_run("bp_rearm", 0, 1'b1, 32'h10, 1'b0, '0, 1'b0);
  endtask

  task automatic test_step();
    do_step("step_plain", 1'b0, 8, 1'b0, 1'b0, 2'(CS_NONE));
    do_step("step_syscall", 1'b0, 8, 1'b1, 1'b0, 2'(CS_SYSCALL));
    do_step("step_bp_min_press", 1'b0, int'(DebounceCnt), 1'b0, 1'b1, 2'(CS_NONE));
    do_step("step_via_resume", 1'b1, 8, 1'b0, 1'b0, 2'(CS_NONE));
  endtask

  task automatic test_syscall();
    logic [31:0] p;
    p = cif.core_pc;
    do_run("syscall", 0, 1'b0, '0, 1'b1, (p + 32'd12) & 32'h3F, 1'b0);
    p = cif.core_pc;
    do_run("syscall_vs_budget", 3, 1'b0, '0, 1'b1, (p + 32'd8) & 32'h3F, 1'b0);
    p = cif.core_pc;
    do_run("bp_vs_syscall", 0, 1'b1, (p + 32'd8) & 32'h3F, 1'b1, (p + 32'd8) & 32'h3F, 1'b0);
    do_run("syscall_after_bp", 0, 1'b1, (p + 32'd8) & 32'h3F, 1'b1, (p + 32'd8) & 32'h3F, 1'b0);
  endtask

  task automatic test_glitch();
    run_mode = 1'b1; budget = 16'd3;
    for (int w = 2; w < int'(DebounceCnt); w++) begin
      exec_q.delete();
      for (int t = 0; t < 20; t++) begin
        btn_resume = (t < w);
        btn_step   = (t < w);
        tick();
      end
      cmp_cnt++;
      if (cif.state !== 2'(ST_HALT) || exec_q.size() != 0) begin
        err_cnt++;
        $display("FAIL glitch_%0d: state=%0d executed=%0d, required 0/0", w, cif.state, exec_q.size());
      end
    end
    btn_resume = 1'b0; btn_step = 1'b0;
  endtask

  task automatic test_random();
    int unsigned bud;
    bit          bpe;
    bit          he;
    for (int i = 0; i < 10; i++) begin
      bud = $urandom_range(0, 20);
      bpe = 1'($urandom_range(0, 1));
      he  = 1'($urandom_range(0, 1));
      if (bud == 0 && !bpe && !he) bud = 7;
      do_run("random", bud, bpe, 32'($urandom_range(0, 15)) << 2,
             he, 32'($urandom_range(0, 15)) << 2, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    run_mode = 1'b1; budget = '0; bp_en = 1'b0; halt_en = 1'b0;
    for (int t = 0; t < 8; t++) begin
      btn_resume = 1'b1;
      tick();
    end
    btn_resume = 1'b0;
    repeat (4) tick();
    cmp_cnt++;
    if (cif.en !== 1'b1) begin err_cnt++; $display("FAIL pre_reset_en: got %0b, required 1", cif.en); end
    #2;
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (cif.en !== 1'b0) begin err_cnt++; $display("FAIL async_en: got %0b, required 0", cif.en); end
    cmp_cnt++;
    if (cif.state !== 2'(ST_HALT)) begin err_cnt++; $display("FAIL async_state: got %0d, required 0", cif.state); end
    cmp_cnt++;
    if (cif.cause !== 2'(CS_NONE)) begin err_cnt++; $display("FAIL async_cause: got %0d, required 0", cif.cause); end
    #3;
    rst_n = 1'b1;
    repeat (10) tick();
    cmp_cnt++;
    if (cif.state !== 2'(ST_HALT)) begin err_cnt++; $display("FAIL post_reset_state: got %0d, required 0", cif.state); end
  endtask

  initial begin
    test_reset();
    test_budget();
    test_breakpoint();
    test_step();
    test_syscall();
    test_glitch();
    do_run("resume_in_run", 40, 1'b0, '0, 1'b0, '0, 1'b1);
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
